// File: rtl/vm_pkg.sv
// Shared coin definitions, FSM state encoding and default parameters
// for the vending machine change dispenser.
package vm_pkg;

  localparam int unsigned NUM_COINS          = 5;
  localparam int unsigned TIMEOUT_DEFAULT    = 1000;
  localparam int unsigned INIT_COUNT_DEFAULT = 20;

  typedef enum logic [2:0] {
    COIN_NICKEL  = 3'd0,
    COIN_DIME    = 3'd1,
    COIN_QUARTER = 3'd2,
    COIN_HALF    = 3'd3,
    COIN_DOLLAR  = 3'd4
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_FINISH,
    ST_FAULT
  } state_e;

  // Face value in cents; codes 5-7 are invalid and map to zero.
  function automatic logic [11:0] coin_value(input logic [2:0] code);
    logic [11:0] v;
    case (code)
      COIN_NICKEL:  v = 12'd5;
      COIN_DIME:    v = 12'd10;
      COIN_QUARTER: v = 12'd25;
      COIN_HALF:    v = 12'd50;
      COIN_DOLLAR:  v = 12'd100;
      default:      v = 12'd0;
    endcase
    return v;
  endfunction

  function automatic logic is_valid_coin(input logic [2:0] code);
    return code < 3'(NUM_COINS);
  endfunction

endpackage

// File: rtl/vm_coin_select.sv
// Greedy coin selector: largest in-stock coin whose value fits the
// remaining amount.
module vm_coin_select
  import vm_pkg::*;
(
  input  logic [11:0]                remaining,
  input  logic [NUM_COINS-1:0][7:0]  inventory,
  output logic [2:0]                 coin,
  output logic                       found
);

  // Coin values rise with code, so the last eligible code wins.
  always_comb begin
    coin  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if ((inventory[i] != '0) && (coin_value(3'(i)) <= remaining)) begin
        coin  = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays out a requested amount one coin at a time via a
// handshake with the coin mechanism, tracking per-denomination inventory.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned INIT_COUNT = INIT_COUNT_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        change_valid,
  input  logic [11:0] change_amount,
  input  logic        eject_done,
  input  logic        restock,
  input  logic [2:0]  restock_coin,
  input  logic [7:0]  restock_count,
  output logic        ready,
  output logic        eject_req,
  output logic [2:0]  eject_coin,
  output logic        done,
  output logic [11:0] shortfall,
  output logic        error,
  output logic        fault
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                     state;
  logic [11:0]                remaining;
  logic [CW-1:0]              tmo_cnt;
  logic [NUM_COINS-1:0][7:0]  inventory;

  logic [2:0]  sel_coin;
  logic        sel_found;
  logic [7:0]  restock_base;
  logic [8:0]  restock_sum;
  logic [7:0]  restock_sat;
  logic        amount_mult5;

  vm_coin_select u_select (
    .remaining (remaining),
    .inventory (inventory),
    .coin      (sel_coin),
    .found     (sel_found)
  );

  always_comb begin
    restock_base = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (restock_coin == 3'(i)) restock_base = inventory[i];
    end
    restock_sum  = {1'b0, restock_base} + {1'b0, restock_count};
    restock_sat  = restock_sum[8] ? '1 : restock_sum[7:0];
    amount_mult5 = ((change_amount % 12'd5) == 12'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      tmo_cnt    <= '0;
      inventory  <= {NUM_COINS{8'(INIT_COUNT)}};
      ready      <= 1'b1;
      eject_req  <= 1'b0;
      eject_coin <= '0;
      done       <= 1'b0;
      shortfall  <= '0;
      error      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (change_valid) begin
            remaining <= change_amount;
            error     <= 1'b0;
            shortfall <= '0;
            ready     <= 1'b0;
            if (change_amount == '0) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else if (!amount_mult5) begin
              shortfall <= change_amount;
              error     <= 1'b1;
              done      <= 1'b1;
              state     <= ST_FINISH;
            end else begin
              state <= ST_SELECT;
            end
          end else if (restock && is_valid_coin(restock_coin)) begin
            inventory[restock_coin] <= restock_sat;
          end
        end

        ST_SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (sel_found) begin
            eject_coin <= sel_coin;
            eject_req  <= 1'b1;
            tmo_cnt    <= '0;
            state      <= ST_EJECT;
          end else begin
            shortfall <= remaining;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FINISH;
          end
        end

        ST_EJECT: begin
          if (eject_done) begin
            inventory[eject_coin] <= inventory[eject_coin] - 8'd1;
            remaining             <= remaining - coin_value(eject_coin);
            eject_req             <= 1'b0;
            state                 <= ST_SELECT;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            // Fault lands exactly TIMEOUT cycles after eject_req rose.
            eject_req <= 1'b0;
            fault     <= 1'b1;
            state     <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end

        ST_FAULT: begin
          eject_req <= 1'b0;
          ready     <= 1'b0;
          fault     <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Randomized self-checking bench for vm_change_dispenser with a greedy
// payout reference model; a second instance starts with empty inventory.
module tb_vm_change_dispenser;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        cv = 1'b0, ed = 1'b0, rs = 1'b0;
  logic [11:0] ca = '0;
  logic [2:0]  rc = '0;
  logic [7:0]  rcnt = '0;

  logic        cv0, cv1, ed0, ed1, rs0, rs1;
  logic        ready0, ready1, req0, req1, done0, done1, err0, err1, flt0, flt1;
  logic [2:0]  coin0, coin1;
  logic [11:0] sf0, sf1;

  logic        o_ready, o_req, o_done, o_err, o_flt;
  logic [2:0]  o_coin;
  logic [11:0] o_sf;

  int n_checks = 0;
  int n_fail   = 0;
  int vals[5] = '{5, 10, 25, 50, 100};
  int minv[2][5];

  always #5 clk = ~clk;

  assign cv0 = cv & ~sel;  assign cv1 = cv & sel;
  assign ed0 = ed & ~sel;  assign ed1 = ed & sel;
  assign rs0 = rs & ~sel;  assign rs1 = rs & sel;

  assign o_ready = sel ? ready1 : ready0;
  assign o_req   = sel ? req1   : req0;
  assign o_done  = sel ? done1  : done0;
  assign o_err   = sel ? err1   : err0;
  assign o_flt   = sel ? flt1   : flt0;
  assign o_coin  = sel ? coin1  : coin0;
  assign o_sf    = sel ? sf1    : sf0;

  vm_change_dispenser #(.INIT_COUNT(20), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .change_valid(cv0), .change_amount(ca),
    .eject_done(ed0), .restock(rs0), .restock_coin(rc), .restock_count(rcnt),
    .ready(ready0), .eject_req(req0), .eject_coin(coin0), .done(done0),
    .shortfall(sf0), .error(err0), .fault(flt0)
  );

  vm_change_dispenser #(.INIT_COUNT(0), .TIMEOUT(TMO)) dut_empty (
    .clk(clk), .reset(reset), .change_valid(cv1), .change_amount(ca),
    .eject_done(ed1), .restock(rs1), .restock_coin(rc), .restock_count(rcnt),
    .ready(ready1), .eject_req(req1), .eject_coin(coin1), .done(done1),
    .shortfall(sf1), .error(err1), .fault(flt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cv = 0; ed = 0; rs = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      minv[0][i] = 20;
      minv[1][i] = 0;
    end
  endtask

  task automatic do_restock(input int code, input int count);
    rs = 1; rc = 3'(code); rcnt = 8'(count);
    tick();
    rs = 0;
    if (code < 5) minv[sel][code] = (minv[sel][code] + count > 255) ? 255 : minv[sel][code] + count;
  endtask

  // Pays out amt on the selected DUT; any restock already driven is dropped.
  task automatic run_change(input int amt, input int lat_max, input bit noise);
    int rem, k, exp_short, idx, lat;
    bit exp_err, got;
    int q[$];
    logic [2:0] held;
    q.delete(); exp_short = 0; exp_err = 0;
    if (amt % 5 != 0) begin
      exp_short = amt; exp_err = 1;
    end else begin
      rem = amt;
      while (rem > 0) begin
        k = -1;
        for (int i = 4; i >= 0; i--)
          if (k < 0 && vals[i] <= rem && minv[sel][i] > 0) k = i;
        if (k < 0) break;
        q.push_back(k); minv[sel][k]--; rem -= vals[k];
      end
      if (rem > 0) begin exp_short = rem; exp_err = 1; end
    end

    cv = 1; ca = 12'(amt);
    tick();
    cv = 0; rs = 0;
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready amt=%0d got %b want 0", amt, o_ready); end
    if (amt % 5 == 0 && amt != 0) begin
      n_checks++;
      if (o_err !== 1'b0 || o_sf !== 12'd0) begin n_fail++; $display("FAIL accept_clear amt=%0d err=%b sf=%0d want 0/0", amt, o_err, o_sf); end
    end
    if (q.size() > 0) begin
      n_checks++;
      if (o_req !== 1'b0) begin n_fail++; $display("FAIL req_early amt=%0d got %b want 0", amt, o_req); end
      tick();
      n_checks++;
      if (o_req !== 1'b1) begin n_fail++; $display("FAIL req_latency amt=%0d got %b want 1", amt, o_req); end
    end

    idx = 0; got = 0;
    for (int c = 0; c < 6000 && !got; c++) begin
      if (o_req) begin
        n_checks++;
        if (idx >= q.size() || o_coin !== 3'(q[idx])) begin
          n_fail++;
          $display("FAIL coin amt=%0d idx=%0d got %0d want %0d", amt, idx, o_coin, (idx < q.size()) ? q[idx] : -1);
        end
        held = o_coin;
        lat = $urandom_range(0, lat_max);
        repeat (lat) begin
          if (noise && $urandom_range(0, 3) == 0) begin
            cv = 1; ca = 12'($urandom_range(5, 200)); rs = 1;
            rc = 3'($urandom_range(0, 7)); rcnt = 8'($urandom);
          end
          tick();
          cv = 0; rs = 0;
          n_checks++;
          if (o_req !== 1'b1 || o_coin !== held || o_done !== 1'b0) begin
            n_fail++; $display("FAIL eject_hold amt=%0d req=%b coin=%0d done=%b want 1/%0d/0", amt, o_req, o_coin, o_done, held);
          end
        end
        ed = 1;
        tick();
        ed = 0; idx++;
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL req_drop amt=%0d got %b want 0", amt, o_req); end
      end else if (o_done) begin
        got = 1;
        n_checks++;
        if (o_sf !== 12'(exp_short) || o_err !== exp_err || idx != q.size()) begin
          n_fail++;
          $display("FAIL result amt=%0d sf=%0d err=%b coins=%0d want %0d/%b/%0d", amt, o_sf, o_err, idx, exp_short, exp_err, q.size());
        end
        tick();
        n_checks++;
        if (o_done !== 1'b0 || o_ready !== 1'b1 || o_sf !== 12'(exp_short) || o_err !== exp_err) begin
          n_fail++;
          $display("FAIL after_done amt=%0d done=%b ready=%b sf=%0d err=%b want 0/1/%0d/%b", amt, o_done, o_ready, o_sf, o_err, exp_short, exp_err);
        end
      end else begin
        tick();
      end
    end
    if (!got) begin n_checks++; n_fail++; $display("FAIL done_timeout amt=%0d got no done want done", amt); end
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    n_checks++;
    if (ready0 !== 1'b1 || req0 !== 1'b0 || coin0 !== 3'd0 || done0 !== 1'b0 ||
        sf0 !== 12'd0 || err0 !== 1'b0 || flt0 !== 1'b0 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got r=%b q=%b c=%0d d=%b s=%0d e=%b f=%b want 1 0 0 0 0 0 0", ready0, req0, coin0, done0, sf0, err0, flt0);
    end
  endtask

  task automatic test_basic_40();
    sel = 0;
    run_change(40, 3, 0);
    run_change(0, 0, 0);
  endtask

  task automatic test_empty_build();
    sel = 1;
    do_restock(2, 5);
    run_change(15, 2, 0);
    do_restock(0, 5);
    run_change(30, 3, 0);
  endtask

  task automatic test_collision();
    sel = 1;
    rs = 1; rc = 3'd4; rcnt = 8'd3;
    run_change(100, 1, 0);
    run_change(5, 1, 0);
    run_change(100, 1, 0);
  endtask

  task automatic test_saturation();
    sel = 1;
    do_restock(4, 200);
    do_restock(4, 100);
    do_restock(6, 50);
    run_change(4095, 0, 0);
    run_change(4095, 0, 0);
  endtask

  task automatic test_reject();
    sel = 0;
    run_change(33, 1, 0);
    run_change(4093, 1, 0);
  endtask

  task automatic test_random();
    int amt;
    sel = 0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        ed = $urandom_range(0, 1);
        do_restock($urandom_range(0, 7), $urandom_range(0, 255));
        ed = 0;
      end
      if ($urandom_range(0, 4) == 0) amt = $urandom_range(0, 4095);
      else amt = 5 * $urandom_range(0, 80);
      run_change(amt, 4, 1);
    end
  endtask

  task automatic test_fault();
    int cnt;
    sel = 0;
    do_reset();
    cv = 1; ca = 12'd25;
    tick();
    cv = 0;
    tick();
    n_checks++;
    if (req0 !== 1'b1 || coin0 !== 3'd2) begin n_fail++; $display("FAIL fault_setup req=%b coin=%0d want 1/2", req0, coin0); end
    cnt = 0;
    while (!flt0 && cnt < int'(TMO) + 10) begin tick(); cnt++; end
    n_checks++;
    if (cnt != int'(TMO)) begin n_fail++; $display("FAIL fault_time got %0d want %0d", cnt, TMO); end
    n_checks++;
    if (req0 !== 1'b0 || ready0 !== 1'b0) begin n_fail++; $display("FAIL fault_outputs req=%b ready=%b want 0/0", req0, ready0); end
    cv = 1; ca = 12'd10; ed = 1;
    repeat (5) tick();
    cv = 0; ed = 0;
    n_checks++;
    if (flt0 !== 1'b1 || ready0 !== 1'b0 || req0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL fault_sticky f=%b r=%b q=%b d=%b want 1/0/0/0", flt0, ready0, req0, done0);
    end
    do_reset();
    n_checks++;
    if (flt0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL fault_clear f=%b r=%b want 0/1", flt0, ready0); end
  endtask

  task automatic test_reset_mid_eject();
    sel = 0;
    run_change(1900, 0, 0);
    cv = 1; ca = 12'd100;
    tick();
    cv = 0;
    tick();
    n_checks++;
    if (req0 !== 1'b1) begin n_fail++; $display("FAIL mid_setup req got %b want 1", req0); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (req0 !== 1'b0 || coin0 !== 3'd0) begin n_fail++; $display("FAIL async_reset req=%b coin=%0d want 0/0", req0, coin0); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin minv[0][i] = 20; minv[1][i] = 0; end
    tick();
    n_checks++;
    if (ready0 !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", ready0); end
    run_change(2000, 0, 0);
    run_change(40, 3, 0);
  endtask

  initial begin
    test_reset();
    test_basic_40();
    test_empty_build();
    test_collision();
    test_saturation();
    test_reject();
    test_random();
    test_fault();
    test_reset_mid_eject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vm_change_dispenser.md
VM_CHANGE_DISPENSER -- requirements
Module: vm_change_dispenser

Interface
REQ-001 The block SHALL have parameter INIT_COUNT, default 20, meaning the per-denomination coin inventory loaded at reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, meaning the maximum cycles to wait for eject_done.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port change_valid, input, 1 bit: one-cycle request to pay out change_amount.
REQ-006 The block SHALL have port change_amount, input, 12 bits: change owed, in cents.
REQ-007 The block SHALL have port eject_done, input, 1 bit: coin mechanism acknowledge for the current coin.
REQ-008 The block SHALL have port restock, input, 1 bit: one-cycle inventory add strobe.
REQ-009 The block SHALL have port restock_coin, input, 3 bits: denomination code to restock.
REQ-010 The block SHALL have port restock_count, input, 8 bits: number of coins to add.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-012 The block SHALL have port eject_req, output, 1 bit: request to the mechanism to eject one coin.
REQ-013 The block SHALL have port eject_coin, output, 3 bits: denomination of the coin being ejected.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port shortfall, output, 12 bits: cents not paid at completion.
REQ-016 The block SHALL have port error, output, 1 bit: last transaction incomplete or rejected.
REQ-017 The block SHALL have port fault, output, 1 bit: mechanism timeout; sticky until reset.

Function
REQ-018 Coin codes SHALL be 0 nickel (5), 1 dime (10), 2 quarter (25), 3 half_dollar (50), 4 dollar (100); codes 5-7 are invalid.
REQ-019 The FSM SHALL have states IDLE, SELECT, EJECT, FINISH and FAULT.
REQ-020 IDLE with change_valid=1 SHALL latch change_amount into remaining, clear error and shortfall, and go to SELECT next cycle.
REQ-021 A change_amount that is not a multiple of 5 SHALL be rejected: no ejection, shortfall=change_amount, error=1, and go to FINISH.
REQ-022 change_amount=0 SHALL go directly to FINISH with shortfall=0 and error=0.
REQ-023 SELECT SHALL pick the largest coin with value <= remaining and inventory > 0, then go to EJECT; eject_req rises 2 cycles after change_valid.
REQ-024 SELECT with remaining>0 and no eligible coin SHALL set shortfall=remaining, error=1, and go to FINISH.
REQ-025 SELECT with remaining=0 SHALL go to FINISH with shortfall=0.
REQ-026 In EJECT, eject_req SHALL stay high and eject_coin stable until eject_done=1.
REQ-027 On eject_done, the block SHALL decrement that coin's inventory, subtract its value from remaining, drop eject_req, and return to SELECT.
REQ-028 eject_done outside EJECT SHALL be ignored.
REQ-029 EJECT SHALL count cycles; reaching TIMEOUT without eject_done SHALL go to FAULT.
REQ-030 FAULT SHALL set fault=1 and eject_req=0 and hold the state until reset; ready=0 in FAULT.
REQ-031 FINISH SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-032 shortfall and error SHALL hold their values until the next accepted request.
REQ-033 restock SHALL be accepted only in IDLE, adds restock_count to the selected inventory, and saturates at 255.
REQ-034 restock with an invalid code, or outside IDLE, SHALL be ignored.
REQ-035 If change_valid and restock are both asserted in IDLE, change_valid SHALL win and restock SHALL be dropped.
REQ-036 change_valid outside IDLE SHALL be ignored.
REQ-037 Inventory counters SHALL be 8 bits each, and remaining SHALL be 12 bits; remaining never underflows per REQ-023.

Reset
REQ-038 Reset SHALL take effect asynchronously at any time, including mid-EJECT, setting state=IDLE, eject_req=0, eject_coin=0, done=0, shortfall=0, error=0, fault=0, remaining=0, timeout counter=0, and all inventories=INIT_COUNT; ready=1 after release.

Structure
REQ-039 Coin codes, coin values, FSM state encodings and the TIMEOUT default SHALL live in shared package vm_pkg.
REQ-040 The greedy selector SHALL be one combinational sub-module, vm_coin_select (inputs remaining and the five inventories; outputs coin code and found).

Verification
REQ-041 INIT inventory, 40 cents, eject_done 3 cycles after each request -> coins quarter, dime, nickel; done pulse; shortfall=0; error=0.
REQ-042 Dimes restocked to 0 is not possible; instead use INIT_COUNT=0 build with nickel=5, quarter=5 restocked, 30 cents -> quarter, nickel; done; shortfall=0.
REQ-043 Only quarters stocked, 15 cents -> no eject_req; shortfall=15; error=1; done pulse.
REQ-044 Request 25 cents, eject_done never arrives -> fault=1 exactly TIMEOUT cycles after eject_req rises; ready=0 until reset.
REQ-045 Reset asserted mid-EJECT -> eject_req drops immediately (asynchronously); inventories return to 20; ready=1 after release.
REQ-046 Request 33 cents -> rejected; shortfall=33; error=1; no ejection; restock and change_valid in the same cycle -> inventory unchanged.
